// File: rtl/mms_seq_pkg.sv
// Shared types and default widths for the motor sequencer core.
package mms_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned NUM_STEPS = 8;
    localparam int unsigned DRV_W     = 32;
    localparam int unsigned DUR_W     = 16;
    localparam int unsigned LOOP_W    = 8;

endpackage

// File: rtl/drive_step_scheduler_step_bank.sv
// Double-buffered step table: the shadow bank takes writes and the active bank takes bulk copies.
// The read port is asynchronous and can look at either bank.
module step_bank #(
    parameter  int unsigned NUM_STEPS = mms_seq_pkg::NUM_STEPS,
    parameter  int unsigned DRV_W     = mms_seq_pkg::DRV_W,
    parameter  int unsigned DUR_W     = mms_seq_pkg::DUR_W,
    parameter  int unsigned LOOP_W    = mms_seq_pkg::LOOP_W,
    localparam int unsigned ADDR_W    = $clog2(NUM_STEPS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DRV_W-1:0]  wr_pattern,
    input  logic [DUR_W-1:0]  wr_duration,
    input  logic [ADDR_W-1:0] cfg_last_step,
    input  logic [LOOP_W-1:0] cfg_loops,
    input  logic              copy,
    input  logic              rd_shadow,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DRV_W-1:0]  rd_pattern,
    output logic [DUR_W-1:0]  rd_duration,
    output logic [ADDR_W-1:0] act_last_step,
    output logic [LOOP_W-1:0] act_loops
);

    logic [DRV_W-1:0] sh_pat  [NUM_STEPS];
    logic [DUR_W-1:0] sh_dur  [NUM_STEPS];
    logic [DRV_W-1:0] act_pat [NUM_STEPS];
    logic [DUR_W-1:0] act_dur [NUM_STEPS];

    // Copy reads the registered shadow, so a write on the same edge is not copied.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                sh_pat[i]  <= '0;
                sh_dur[i]  <= '0;
                act_pat[i] <= '0;
                act_dur[i] <= '0;
            end
            act_last_step <= '0;
            act_loops     <= '0;
        end else begin
            if (wr_en) begin
                sh_pat[wr_addr] <= wr_pattern;
                sh_dur[wr_addr] <= wr_duration;
            end
            if (copy) begin
                for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                    act_pat[i] <= sh_pat[i];
                    act_dur[i] <= sh_dur[i];
                end
                act_last_step <= cfg_last_step;
                act_loops     <= cfg_loops;
            end
        end
    end

    always_comb begin
        rd_pattern  = rd_shadow ? sh_pat[rd_idx] : act_pat[rd_idx];
        rd_duration = rd_shadow ? sh_dur[rd_idx] : act_dur[rd_idx];
    end

endmodule

// File: rtl/drive_step_scheduler.sv
// Plays the active step table onto the H-bridge drive word for a programmed number of passes.
// Supports a latch deferred to the pass boundary and an abort on a second trigger edge.
module drive_step_scheduler #(
    parameter  int unsigned NUM_STEPS = mms_seq_pkg::NUM_STEPS,
    parameter  int unsigned DRV_W     = mms_seq_pkg::DRV_W,
    parameter  int unsigned DUR_W     = mms_seq_pkg::DUR_W,
    parameter  int unsigned LOOP_W    = mms_seq_pkg::LOOP_W,
    localparam int unsigned ADDR_W    = $clog2(NUM_STEPS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DRV_W-1:0]  wr_pattern,
    input  logic [DUR_W-1:0]  wr_duration,
    input  logic [ADDR_W-1:0] cfg_last_step,
    input  logic [LOOP_W-1:0] cfg_loops,
    input  logic              latch_data,
    input  logic              control_trigger,
    output logic [DRV_W-1:0]  driver_io,
    output logic              busy,
    output logic              update_cycle_complete,
    output logic [ADDR_W-1:0] step_idx
);
    import mms_seq_pkg::*;

    state_t            state_q, state_d;
    logic              trig_q, trig_edge;
    logic [DUR_W-1:0]  hold_q, hold_d, hold_load;
    logic [LOOP_W-1:0] pass_q, pass_d;
    logic              pend_q, pend_d;
    logic [DRV_W-1:0]  drv_d;
    logic [ADDR_W-1:0] idx_d, rd_idx, act_last_step;
    logic              pulse_d, copy, at_end, more, boundary;
    logic [DRV_W-1:0]  rd_pattern;
    logic [DUR_W-1:0]  rd_duration;
    logic [LOOP_W-1:0] act_loops;

    step_bank #(
        .NUM_STEPS(NUM_STEPS),
        .DRV_W    (DRV_W),
        .DUR_W    (DUR_W),
        .LOOP_W   (LOOP_W)
    ) u_bank (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_pattern   (wr_pattern),
        .wr_duration  (wr_duration),
        .cfg_last_step(cfg_last_step),
        .cfg_loops    (cfg_loops),
        .copy         (copy),
        .rd_shadow    (copy),
        .rd_idx       (rd_idx),
        .rd_pattern   (rd_pattern),
        .rd_duration  (rd_duration),
        .act_last_step(act_last_step),
        .act_loops    (act_loops)
    );

    assign trig_edge = control_trigger & ~trig_q;
    assign at_end    = (hold_q == '0) && (step_idx == act_last_step);
    assign more      = (act_loops == '0) || (pass_q > LOOP_W'(1));
    assign boundary  = (state_q == RUN) && !trig_edge && at_end;
    // Whenever a copy happens this edge, the step being fetched comes straight from the shadow bank.
    assign copy      = (state_q == IDLE) ? latch_data : (boundary && (pend_q || latch_data));
    assign rd_idx    = ((state_q == RUN) && !at_end) ? step_idx + ADDR_W'(1) : '0;
    assign hold_load = (rd_duration == '0) ? '0 : rd_duration - DUR_W'(1);
    assign busy      = (state_q == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q               <= IDLE;
            trig_q                <= 1'b0;
            hold_q                <= '0;
            pass_q                <= '0;
            pend_q                <= 1'b0;
            driver_io             <= '0;
            step_idx              <= '0;
            update_cycle_complete <= 1'b0;
        end else begin
            state_q               <= state_d;
            trig_q                <= control_trigger;
            hold_q                <= hold_d;
            pass_q                <= pass_d;
            pend_q                <= pend_d;
            driver_io             <= drv_d;
            step_idx              <= idx_d;
            update_cycle_complete <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig_edge) state_d = RUN;
            RUN:     if (trig_edge || (at_end && !more)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drv_d   = driver_io;
        idx_d   = step_idx;
        hold_d  = hold_q;
        pass_d  = pass_q;
        pend_d  = pend_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (trig_edge) begin
                    drv_d  = rd_pattern;
                    idx_d  = '0;
                    hold_d = hold_load;
                    pass_d = copy ? cfg_loops : act_loops;
                end
            end
            RUN: begin
                if (trig_edge) begin
                    drv_d  = '0;
                    idx_d  = '0;
                    pend_d = 1'b0;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - DUR_W'(1);
                    pend_d = pend_q || latch_data;
                end else if (!at_end) begin
                    drv_d  = rd_pattern;
                    idx_d  = rd_idx;
                    hold_d = hold_load;
                    pend_d = pend_q || latch_data;
                end else begin
                    pulse_d = 1'b1;
                    pend_d  = 1'b0;
                    if (more) begin
                        drv_d  = rd_pattern;
                        idx_d  = '0;
                        hold_d = hold_load;
                        if (act_loops != '0) pass_d = pass_q - LOOP_W'(1);
                    end else begin
                        drv_d = '0;
                        idx_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_drive_step_scheduler.sv
// Directed self-checking bench for drive_step_scheduler.
module tb_drive_step_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_pattern;
    logic [15:0] wr_duration;
    logic [2:0]  cfg_last_step;
    logic [7:0]  cfg_loops;
    logic        latch_data;
    logic        control_trigger;
    logic [31:0] driver_io;
    logic        busy;
    logic        update_cycle_complete;
    logic [2:0]  step_idx;

    int total = 0;
    int bad   = 0;

    logic [31:0] pat_seq [6] = '{32'hA5A5_0001, 32'hA5A5_0001, 32'h0000_00F0,
                                 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    logic [2:0]  idx_seq [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2};

    always #5 clock = ~clock;

    drive_step_scheduler dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .wr_en                (wr_en),
        .wr_addr              (wr_addr),
        .wr_pattern           (wr_pattern),
        .wr_duration          (wr_duration),
        .cfg_last_step        (cfg_last_step),
        .cfg_loops            (cfg_loops),
        .latch_data           (latch_data),
        .control_trigger      (control_trigger),
        .driver_io            (driver_io),
        .busy                 (busy),
        .update_cycle_complete(update_cycle_complete),
        .step_idx             (step_idx)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [31:0] p, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_pattern = p; wr_duration = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_latch();
        latch_data = 1'b1;
        tick();
        latch_data = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_pattern = '0; wr_duration = '0;
        cfg_last_step = '0; cfg_loops = '0; latch_data = 1'b0; control_trigger = 1'b0;
        tick(); tick();
        total++;
        if (driver_io !== 32'h0 || busy !== 1'b0 || update_cycle_complete !== 1'b0 || step_idx !== 3'd0) begin
            bad++;
            $display("FAIL reset: drv=%h busy=%b pulse=%b idx=%0d, want 0/0/0/0",
                     driver_io, busy, update_cycle_complete, step_idx);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (driver_io !== 32'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: drv=%h busy=%b, want 0/0", driver_io, busy);
        end
    endtask

    task automatic test_single_pass();
        write_entry(3'd0, 32'hA5A5_0001, 16'd2);
        write_entry(3'd1, 32'h0000_00F0, 16'd0);
        write_entry(3'd2, 32'hFFFF_0000, 16'd3);
        cfg_last_step = 3'd2; cfg_loops = 8'd1;
        do_latch();
        control_trigger = 1'b1;
        tick();
        control_trigger = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (driver_io !== pat_seq[i] || step_idx !== idx_seq[i] || busy !== 1'b1 || update_cycle_complete !== 1'b0) begin
                bad++;
                $display("FAIL single_step%0d: drv=%h idx=%0d busy=%b pulse=%b, want %h/%0d/1/0",
                         i, driver_io, step_idx, busy, update_cycle_complete, pat_seq[i], idx_seq[i]);
            end
            tick();
        end
        total++;
        if (driver_io !== 32'h0 || busy !== 1'b0 || update_cycle_complete !== 1'b1 || step_idx !== 3'd0) begin
            bad++;
            $display("FAIL single_end: drv=%h busy=%b pulse=%b idx=%0d, want 0/0/1/0",
                     driver_io, busy, update_cycle_complete, step_idx);
        end
        tick();
        total++;
        if (update_cycle_complete !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_after: pulse=%b busy=%b, want 0/0", update_cycle_complete, busy);
        end
    endtask

    task automatic test_multi_pass();
        int pulses;
        logic exp_pulse;
        pulses = 0;
        cfg_loops = 8'd3;
        do_latch();
        control_trigger = 1'b1;
        tick();
        control_trigger = 1'b0;
        for (int i = 0; i < 18; i++) begin
            exp_pulse = (i % 6 == 0) && (i != 0);
            if (update_cycle_complete === 1'b1) pulses++;
            total++;
            if (driver_io !== pat_seq[i % 6] || busy !== 1'b1 || update_cycle_complete !== exp_pulse) begin
                bad++;
                $display("FAIL multi_cycle%0d: drv=%h busy=%b pulse=%b, want %h/1/%b",
                         i, driver_io, busy, update_cycle_complete, pat_seq[i % 6], exp_pulse);
            end
            tick();
        end
        if (update_cycle_complete === 1'b1) pulses++;
        total++;
        if (driver_io !== 32'h0 || busy !== 1'b0 || update_cycle_complete !== 1'b1) begin
            bad++;
            $display("FAIL multi_end: drv=%h busy=%b pulse=%b, want 0/0/1", driver_io, busy, update_cycle_complete);
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL multi_pulses: got %0d, want 3", pulses);
        end
        tick();
    endtask

    task automatic test_live_latch();
        logic [31:0] exp_drv;
        logic        exp_pulse;
        cfg_loops = 8'd0;
        do_latch();
        control_trigger = 1'b1;
        tick();
        control_trigger = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_drv   = (i < 6) ? pat_seq[i] : 32'h1111_1111;
            exp_pulse = (i >= 6);
            total++;
            if (driver_io !== exp_drv || busy !== 1'b1 || update_cycle_complete !== exp_pulse) begin
                bad++;
                $display("FAIL live_cycle%0d: drv=%h busy=%b pulse=%b, want %h/1/%b",
                         i, driver_io, busy, update_cycle_complete, exp_drv, exp_pulse);
            end
            if (i == 0) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_pattern = 32'h1111_1111; wr_duration = 16'd1;
            end else if (i == 1) begin
                wr_en = 1'b0; cfg_last_step = 3'd0; latch_data = 1'b1;
            end else if (i == 2) begin
                latch_data = 1'b0;
            end
            tick();
        end
        control_trigger = 1'b1;
        tick();
        control_trigger = 1'b0;
        total++;
        if (driver_io !== 32'h0 || busy !== 1'b0 || update_cycle_complete !== 1'b0 || step_idx !== 3'd0) begin
            bad++;
            $display("FAIL live_abort: drv=%h busy=%b pulse=%b idx=%0d, want 0/0/0/0",
                     driver_io, busy, update_cycle_complete, step_idx);
        end
        tick();
    endtask

    task automatic test_held_trigger();
        int busy_cycles;
        int pulses;
        busy_cycles = 0; pulses = 0;
        cfg_loops = 8'd1;
        do_latch();
        control_trigger = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            if (update_cycle_complete === 1'b1) pulses++;
        end
        control_trigger = 1'b0;
        tick();
        total++;
        if (busy_cycles != 1 || pulses != 1) begin
            bad++;
            $display("FAIL held_trigger: busy_cycles=%0d pulses=%0d, want 1/1", busy_cycles, pulses);
        end
    endtask

    task automatic test_latch_with_trigger();
        write_entry(3'd0, 32'hCAFE_0000, 16'd2);
        wr_en = 1'b1; wr_addr = 3'd0; wr_pattern = 32'hDEAD_BEEF; wr_duration = 16'd5;
        latch_data = 1'b1; control_trigger = 1'b1;
        tick();
        wr_en = 1'b0; latch_data = 1'b0; control_trigger = 1'b0;
        total++;
        if (driver_io !== 32'hCAFE_0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL latch_trig_start: drv=%h busy=%b, want cafe0000/1", driver_io, busy);
        end
        tick();
        total++;
        if (driver_io !== 32'hCAFE_0000 || busy !== 1'b1 || update_cycle_complete !== 1'b0) begin
            bad++;
            $display("FAIL latch_trig_hold: drv=%h busy=%b pulse=%b, want cafe0000/1/0",
                     driver_io, busy, update_cycle_complete);
        end
        tick();
        total++;
        if (driver_io !== 32'h0 || busy !== 1'b0 || update_cycle_complete !== 1'b1) begin
            bad++;
            $display("FAIL latch_trig_end: drv=%h busy=%b pulse=%b, want 0/0/1",
                     driver_io, busy, update_cycle_complete);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        cfg_loops = 8'd0;
        do_latch();
        control_trigger = 1'b1;
        tick();
        control_trigger = 1'b0;
        tick();
        total++;
        if (driver_io !== 32'hDEAD_BEEF || busy !== 1'b1) begin
            bad++;
            $display("FAIL premid_run: drv=%h busy=%b, want deadbeef/1", driver_io, busy);
        end
        #3 reset_n = 1'b0;
        #1;
        total++;
        if (driver_io !== 32'h0 || busy !== 1'b0 || update_cycle_complete !== 1'b0 || step_idx !== 3'd0) begin
            bad++;
            $display("FAIL async_reset: drv=%h busy=%b pulse=%b idx=%0d, want 0/0/0/0",
                     driver_io, busy, update_cycle_complete, step_idx);
        end
        tick();
        reset_n = 1'b1;
        tick();
        control_trigger = 1'b1;
        tick();
        control_trigger = 1'b0;
        total++;
        if (driver_io !== 32'h0 || busy !== 1'b1 || update_cycle_complete !== 1'b0) begin
            bad++;
            $display("FAIL zero_bank_start: drv=%h busy=%b pulse=%b, want 0/1/0",
                     driver_io, busy, update_cycle_complete);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (driver_io !== 32'h0 || busy !== 1'b1 || update_cycle_complete !== 1'b1) begin
                bad++;
                $display("FAIL zero_bank_cycle%0d: drv=%h busy=%b pulse=%b, want 0/1/1",
                         i, driver_io, busy, update_cycle_complete);
            end
        end
        control_trigger = 1'b1;
        tick();
        control_trigger = 1'b0;
        total++;
        if (busy !== 1'b0 || update_cycle_complete !== 1'b0) begin
            bad++;
            $display("FAIL zero_bank_abort: busy=%b pulse=%b, want 0/0", busy, update_cycle_complete);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_live_latch();
        test_held_trigger();
        test_latch_with_trigger();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drive_step_scheduler.md
# drive_step_scheduler

Table-driven step scheduler that sequences the 32-bit H-bridge drive word (`driver_io`) inside the motor sequencer core. It holds a double-buffered table of up to NUM_STEPS (pattern, duration) entries, loaded through a simple write port from the SPI command decoder. On a `control_trigger` rising edge it plays the active table for a programmed number of passes. It sits between the SPI register file and the pad mux, and produces `update_cycle_complete` at every pass boundary.

## Interface
- NUM_STEPS, 8: table depth; power of two, ≥2. ADDR_W = log2(NUM_STEPS).
- DRV_W, 32: drive word width.
- DUR_W, 16: step duration width, in clock cycles.
- LOOP_W, 8: pass-count width.
- clock  in  1  core clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write one shadow-table entry this cycle.
- wr_addr  in  ADDR_W  shadow entry index.
- wr_pattern  in  DRV_W  drive word for that entry.
- wr_duration  in  DUR_W  hold cycles for that entry; 0 is treated as 1.
- cfg_last_step  in  ADDR_W  index of the final step per pass (shadow config).
- cfg_loops  in  LOOP_W  passes per run; 0 = run until abort (shadow config).
- latch_data  in  1  level; copy shadow table and config into the active bank.
- control_trigger  in  1  level; rising edge starts the run (IDLE) or aborts it (RUN).
- driver_io  out  DRV_W  registered drive word.
- busy  out  1  high while in RUN.
- update_cycle_complete  out  1  one-cycle pulse at the end of each pass.
- step_idx  out  ADDR_W  current step index (registered).

## Operation
- States: IDLE and RUN.
- Trigger edge detection: `trig_edge = control_trigger & ~trig_q`. `trig_q` is a register that resets to 0.
- Writes: `wr_en` updates the shadow bank only. The active bank is never written directly.
- Latch in IDLE: `latch_data` high copies shadow → active (all entries plus cfg_last_step and cfg_loops) on that edge.
- Latch in RUN: `latch_data` high sets `latch_pending`. The copy happens at the next pass boundary, before step 0 of the next pass is fetched. `latch_pending` then clears.
- IDLE → RUN on `trig_edge`:
  - step_idx = 0.
  - driver_io = active pattern[0].
  - hold counter = max(dur[0], 1) − 1.
  - pass counter = active loops.
- RUN, hold counter > 0: decrement the counter; outputs are unchanged.
- RUN, hold counter == 0 and step_idx < last_step: advance to step_idx+1, load its pattern and duration.
- RUN, hold counter == 0 and step_idx == last_step: pass boundary.
  - Pulse update_cycle_complete.
  - Apply a pending latch.
  - loops==0 or pass counter > 1: decrement the pass counter (not when loops==0) and restart at step 0 using the (possibly new) active bank.
  - Otherwise: go to IDLE with driver_io = 0 and step_idx = 0.
- RUN, `trig_edge`: abort immediately. Go to IDLE with driver_io = 0 and step_idx = 0, no pulse, and clear `latch_pending`.
- Precedence on the same edge:
  - abort beats a pass boundary;
  - latch in IDLE is applied before a simultaneous trigger, so the run uses the new bank;
  - a write and a latch on the same edge: the latch copies the pre-write shadow contents.
- Reset values: driver_io 0, busy 0, update_cycle_complete 0, step_idx 0, both banks and configs 0, `latch_pending` 0, `trig_q` 0. Reset mid-run returns to IDLE asynchronously.

## Timing
- Trigger high at edge T (low at T−1): busy and pattern[0] are visible after edge T. The pattern is never combinational from inputs.
- Step k is visible for exactly max(dur[k], 1) cycles.
- One pass = Σ max(dur[k], 1) cycles for k = 0..last_step.
- update_cycle_complete is high during the first cycle of the next pass, or the first IDLE cycle after the last pass.
- Back-to-back passes have no gap cycle.
- The hold counter is DUR_W bits and never wraps: the decrement only occurs when the counter is nonzero.
- After the final pass, busy falls on the same edge at which driver_io clears.

## Structure
- Shared package `mms_seq_pkg`: state enum (IDLE, RUN) and default widths (DRV_W, DUR_W, LOOP_W, NUM_STEPS).
- Sub-module `step_bank`:
  - shadow and active register arrays plus config;
  - write port, bulk-copy strobe, asynchronous read by index.
- Top level: edge detect, FSM, counters, output registers.

## Test plan
- Load 3 steps (0xA5A5_0001/d=2, 0x0000_00F0/d=0, 0xFFFF_0000/d=3), last_step=2, loops=1, latch, trigger → driver_io sequence 2,1,3 cycles; single pulse at cycle 7 after trigger; busy low there.
- loops=3, same table → three gapless 6-cycle passes, three pulses spaced 6 cycles, then IDLE with driver_io=0.
- loops=0, rewrite shadow and latch mid-pass → old pattern until boundary, new table from next step 0; second trigger edge aborts with no pulse.
- Trigger held high for 20 cycles in IDLE → exactly one run starts (edge-only); latch and trigger on same edge → run uses new bank.
- Assert reset_n mid-step → outputs go to reset values immediately; after release, trigger with zeroed bank gives driver_io=0 with a pulse every cycle (loops=0, last_step=0, d=0).
